fib_sweep_controller: RTL
=========================

FIB_SWEEP_CONTROLLER -- requirements
Module: fib_sweep_controller

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the result width in bits.
REQ-002 Parameter MAX_N, default 23, SHALL set the largest index tested; F(MAX_N) must fit WIDTH.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of wait cycles per index; range 1..255.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge triggered.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a sweep.
REQ-007 n_first  in  5  first index of the sweep.
REQ-008 n_last  in  5  last index of the sweep.
REQ-009 calc_reset  out  1  synchronous reset pulse to the calculator.
REQ-010 calc_n  out  5  index presented to the calculator.
REQ-011 calc_begin  out  1  one-cycle launch strobe to the calculator.
REQ-012 calc_done  in  1  calculator completion level.
REQ-013 calc_result  in  WIDTH  calculator result, valid while calc_done=1.
REQ-014 busy  out  1  high from the cycle after start is accepted until the cycle finished pulses.
REQ-015 finished  out  1  one-cycle pulse at sweep end.
REQ-016 pass_count, fail_count  out  6 each  tallies for the current or last sweep.
REQ-017 first_fail_valid  out  1, first_fail_n  out  5  first failing index.
REQ-018 last_cycles  out  8  cycle count of the most recently checked index.

Function
REQ-019 The block SHALL implement states IDLE, PRIME, CAL_RST, LAUNCH, WAIT, CHECK, FINISH.
REQ-020 In IDLE, start=1 SHALL latch n_first and n_last, clamp each to MAX_N, clear all counts and first-fail status, and move to PRIME; start while not IDLE SHALL be ignored.
REQ-021 The golden generator SHALL hold the pair (a,b), initialised to (0,1) on entry to PRIME, giving F(0)=0 and F(1)=1.
REQ-022 PRIME SHALL advance (a,b) to (b,a+b) once per cycle, n_first times, so that a=F(n_first); then it SHALL go to CAL_RST, or to FINISH if the clamped n_first > n_last.
REQ-023 CAL_RST SHALL assert calc_reset for exactly one cycle, then go to LAUNCH.
REQ-024 LAUNCH SHALL drive calc_n=current index and calc_begin=1 for exactly one cycle, set the cycle counter to 1, then go to WAIT.
REQ-025 calc_n SHALL hold the current index from LAUNCH through CHECK.
REQ-026 WAIT SHALL sample calc_done each cycle; when calc_done=0 it SHALL increment the counter.
REQ-027 When calc_done=1 in WAIT, the block SHALL capture calc_result and go to CHECK.
REQ-028 If the counter reaches TIMEOUT with calc_done=0, WAIT SHALL record a fail, set last_cycles=TIMEOUT, and go to CHECK without comparing.
REQ-029 calc_done SHALL be ignored outside WAIT.
REQ-030 CHECK SHALL, for a non-timeout index, compare the captured result with a over the full WIDTH: equal increments pass_count, else fail_count.
REQ-031 CHECK SHALL set last_cycles to the final counter value.
REQ-032 The first fail of a sweep SHALL set first_fail_valid=1 and first_fail_n=index; later fails SHALL NOT change them.
REQ-033 After CHECK, if index=n_last the block SHALL go to FINISH.
REQ-034 Otherwise, after CHECK the block SHALL increment the index, advance (a,b) once, and go to CAL_RST.
REQ-035 FINISH SHALL pulse finished for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-036 Counts, first-fail status and last_cycles SHALL hold their values in IDLE until the next accepted start.
REQ-037 Golden arithmetic SHALL be WIDTH bits, modulo 2^WIDTH; no overflow flag SHALL be produced.

Reset
REQ-038 reset=0 SHALL immediately force state IDLE and drive calc_reset=0, calc_begin=0, calc_n=0, busy=0, finished=0, counts=0, first_fail_valid=0, first_fail_n=0, last_cycles=0, a=0, b=1.
REQ-039 Reset mid-sweep SHALL abandon the sweep with no finished pulse.
REQ-040 After reset deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-041 Calculator model responding in 5 cycles, start with n_first=0, n_last=23 -> 24 CAL_RST/LAUNCH pairs, pass_count=24, fail_count=0, last_cycles=5, single finished pulse.
REQ-042 Model returning a wrong value for n=10 only, sweep 0..23 -> pass_count=23, fail_count=1, first_fail_valid=1, first_fail_n=10.
REQ-043 Model that never asserts calc_done, TIMEOUT=8, sweep 3..4 -> fail_count=2, last_cycles=8, first_fail_n=3.
REQ-044 n_first=7, n_last=2 -> no calc_begin, finished pulses, counts=0; n_first=20, n_last=31 -> clamped sweep of 4 indices with the last calc_n=23.
REQ-045 Reset asserted during WAIT at n=12 -> all outputs at reset values, no finished pulse; a start asserted while busy is ignored.

Source files
------------

// File: rtl/fib_sweep_controller_if.sv
// -----------------------------------------------------------------------------
// fib_sweep_controller_if
//
// Purpose:
//    Bundles the handshake between the sweep controller and the Fibonacci
//    calculator under test. The controller owns reset, index and launch.
//    The calculator answers with a done level and a result word.
//
// Signals:
//    calc_reset   controller -> calculator  synchronous reset pulse
//    calc_n       controller -> calculator  index to compute
//    calc_begin   controller -> calculator  one-cycle launch strobe
//    calc_done    calculator -> controller  completion level
//    calc_result  calculator -> controller  result, valid while calc_done=1
//
// Modports:
//    master  the sweep controller side
//    slave   the calculator side
// -----------------------------------------------------------------------------
interface fib_sweep_controller_if #(
   parameter int WIDTH = 16
);
   logic             calc_reset;
   logic [4:0]       calc_n;
   logic             calc_begin;
   logic             calc_done;
   logic [WIDTH-1:0] calc_result;

   modport master (
      output calc_reset,
      output calc_n,
      output calc_begin,
      input  calc_done,
      input  calc_result
   );

   modport slave (
      input  calc_reset,
      input  calc_n,
      input  calc_begin,
      output calc_done,
      output calc_result
   );
endinterface

// File: rtl/fib_sweep_controller.sv
// -----------------------------------------------------------------------------
// fib_sweep_controller
//
// Purpose:
//    Sweeps a Fibonacci calculator over a range of indices. For each index it
//    resets the calculator, launches it, and waits a bounded number of cycles
//    for completion. It then compares the returned value against an internal
//    golden Fibonacci generator. Pass/fail tallies, the first failing index
//    and the latency of the last checked index are reported.
//
// Parameters:
//    WIDTH    result width in bits; golden arithmetic wraps modulo 2^WIDTH
//    MAX_N    largest index tested; requested indices are clamped to it
//    TIMEOUT  maximum wait cycles per index (1..255)
//
// Ports:
//    clk               rising-edge clock
//    rst_n             asynchronous active-low reset
//    start             one-cycle sweep request, honoured only when idle
//    n_first, n_last   requested sweep range
//    calc              calculator handshake (master side)
//    busy              high while a sweep is in progress; low during finished
//    finished          one-cycle pulse when a sweep completes
//    pass_count        indices whose result matched
//    fail_count        indices that mismatched or timed out
//    first_fail_valid  a failure has been seen in this sweep
//    first_fail_n      index of that first failure
//    last_cycles       wait cycles of the most recently checked index
// -----------------------------------------------------------------------------
module fib_sweep_controller #(
   parameter int WIDTH   = 16,
   parameter int MAX_N   = 23,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [4:0]                n_first,
   input  logic [4:0]                n_last,
   fib_sweep_controller_if.master    calc,
   output logic                      busy,
   output logic                      finished,
   output logic [5:0]                pass_count,
   output logic [5:0]                fail_count,
   output logic                      first_fail_valid,
   output logic [4:0]                first_fail_n,
   output logic [7:0]                last_cycles
);

   localparam logic [4:0] MAX_N_L   = 5'(MAX_N);
   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_CAL_RST,
      S_LAUNCH,
      S_WAIT,
      S_CHECK,
      S_FINISH
   } state_t;

   state_t           state_q,      state_d;
   logic [4:0]       idx_q,        idx_d;
   logic [4:0]       last_q,       last_d;
   logic [4:0]       prime_cnt_q,  prime_cnt_d;
   logic [WIDTH-1:0] a_q,          a_d;
   logic [WIDTH-1:0] b_q,          b_d;
   logic [7:0]       cnt_q,        cnt_d;
   logic [WIDTH-1:0] result_q,     result_d;
   logic             timed_out_q,  timed_out_d;
   logic [5:0]       pass_q,       pass_d;
   logic [5:0]       fail_q,       fail_d;
   logic             ffv_q,        ffv_d;
   logic [4:0]       ffn_q,        ffn_d;
   logic [7:0]       lcyc_q,       lcyc_d;
   logic             fail_now;

   function automatic logic [4:0] clamp_n(input logic [4:0] n);
      return (n > MAX_N_L) ? MAX_N_L : n;
   endfunction

   // State and datapath registers; reset leaves the golden pair at (0,1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         last_q      <= '0;
         prime_cnt_q <= '0;
         a_q         <= '0;
         b_q         <= WIDTH'(1);
         cnt_q       <= '0;
         result_q    <= '0;
         timed_out_q <= 1'b0;
         pass_q      <= '0;
         fail_q      <= '0;
         ffv_q       <= 1'b0;
         ffn_q       <= '0;
         lcyc_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         prime_cnt_q <= prime_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         timed_out_q <= timed_out_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         ffv_q       <= ffv_d;
         ffn_q       <= ffn_d;
         lcyc_q      <= lcyc_d;
      end
   end

   // Next-state and datapath updates. Everything holds by default.
   // idx_q doubles as the index presented to the calculator.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      prime_cnt_d = prime_cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      timed_out_d = timed_out_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      ffv_d       = ffv_q;
      ffn_d       = ffn_q;
      lcyc_d      = lcyc_q;
      fail_now    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d       = clamp_n(n_first);
               last_d      = clamp_n(n_last);
               prime_cnt_d = clamp_n(n_first);
               a_d         = '0;
               b_d         = WIDTH'(1);
               pass_d      = '0;
               fail_d      = '0;
               ffv_d       = 1'b0;
               ffn_d       = '0;
               lcyc_d      = '0;
               state_d     = S_PRIME;
            end
         end

         // Step the golden pair forward until a = F(first index).
         // An inverted range is only detected after priming.
         S_PRIME: begin
            if (prime_cnt_q != 5'd0) begin
               a_d         = b_q;
               b_d         = a_q + b_q;
               prime_cnt_d = prime_cnt_q - 5'd1;
            end else if (idx_q > last_q) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_CAL_RST;
            end
         end

         S_CAL_RST: begin
            state_d = S_LAUNCH;
         end

         S_LAUNCH: begin
            cnt_d   = 8'd1;
            state_d = S_WAIT;
         end

         // Completion wins over timeout when both land on the same cycle.
         // So an answer in exactly TIMEOUT cycles is still compared.
         S_WAIT: begin
            if (calc.calc_done) begin
               result_d    = calc.calc_result;
               timed_out_d = 1'b0;
               state_d     = S_CHECK;
            end else if (cnt_q >= TIMEOUT_L) begin
               timed_out_d = 1'b1;
               state_d     = S_CHECK;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_CHECK: begin
            fail_now = timed_out_q || (result_q != a_q);
            if (fail_now) begin
               fail_d = fail_q + 6'd1;
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffn_d = idx_q;
               end
            end else begin
               pass_d = pass_q + 6'd1;
            end
            lcyc_d = cnt_q;
            if (idx_q == last_q) begin
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + 5'd1;
               a_d     = b_q;
               b_d     = a_q + b_q;
               state_d = S_CAL_RST;
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign calc.calc_reset = (state_q == S_CAL_RST);
   assign calc.calc_begin = (state_q == S_LAUNCH);
   assign calc.calc_n     = idx_q;

   assign busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign finished = (state_q == S_FINISH);

   assign pass_count       = pass_q;
   assign fail_count       = fail_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_n     = ffn_q;
   assign last_cycles      = lcyc_q;

endmodule
